int_arbiter: RTL and testbench



---
 rtl/int_arbiter.sv | 152 +++++++++++++++
 tb/tb_int_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Interrupt request arbiter: edge capture, masking, fixed priority with
// nesting, and single-cycle push strobe towards the interrupt context stack.
module int_arbiter #(
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int NUM_IRQ = 4,
    parameter int STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH_MEM-1:0] VEC_BASE = 16'h0100,
    parameter logic [ADDR_WIDTH_MEM-1:0] VEC_STRIDE = 16'h0010,
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int CNT_W = $clog2(STACK_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IRQ-1:0]        irq,
    input  logic [NUM_IRQ-1:0]        irq_mask,
    input  logic                      int_ack,
    input  logic                      ret_valid,
    output logic                      int_req,
    output logic                      int_set,
    output logic [ID_W-1:0]           int_id,
    output logic [ADDR_WIDTH_MEM-1:0] int_vec,
    output logic [CNT_W-1:0]          nest_cnt,
    output logic [NUM_IRQ-1:0]        in_service,
    output logic [NUM_IRQ-1:0]        pending,
    output logic                      err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SET  = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_d_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [CNT_W-1:0]   nest_q, nest_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               err_q, err_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] allowed;
    logic [NUM_IRQ-1:0] elig;
    logic               room;
    logic               any_elig;
    logic [ID_W-1:0]    win;

    // Eligibility: enabled pending lines strictly above the active level,
    // only while the context stack still has room.
    always_comb begin
        logic seen;
        seen = 1'b0;
        rise = irq & ~irq_d_q;
        for (int k = 0; k < NUM_IRQ; k++) begin
            seen = seen | in_service_q[k];
            allowed[k] = ~seen;
        end
        room = (nest_q < CNT_W'(STACK_DEPTH));
        elig = pending_q & irq_mask & allowed & {NUM_IRQ{room}};
        any_elig = |elig;
        win = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (elig[k]) win = ID_W'(k);
        end
    end

    // Next-state: request/push sequencing, returns and error tracking.
    always_comb begin
        logic done;
        done = 1'b0;
        state_d = state_q;
        id_d = id_q;
        pending_d = pending_q;
        in_service_d = in_service_q;
        nest_d = nest_q;
        err_d = err_q;
        unique case (state_q)
            IDLE: begin
                if (any_elig) state_d = REQ;
            end
            REQ: begin
                if (any_elig) id_d = win;
                if (!any_elig) begin
                    state_d = IDLE;
                end else if (int_ack && !ret_valid) begin
                    state_d = SET;
                end
            end
            SET: begin
                state_d = HOLD;
                pending_d[id_q] = 1'b0;
                in_service_d[id_q] = 1'b1;
                nest_d = nest_q + 1'b1;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (ret_valid) begin
            if (state_q == SET || nest_q == '0) begin
                err_d = 1'b1;
            end else begin
                nest_d = nest_q - 1'b1;
                for (int k = 0; k < NUM_IRQ; k++) begin
                    if (!done && in_service_q[k]) begin
                        in_service_d[k] = 1'b0;
                        done = 1'b1;
                    end
                end
            end
        end
        // New edges after the clear so an edge during SET is not lost.
        pending_d = pending_d | rise;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            irq_d_q <= '0;
            pending_q <= '0;
            in_service_q <= '0;
            nest_q <= '0;
            id_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_d_q <= irq;
            pending_q <= pending_d;
            in_service_q <= in_service_d;
            nest_q <= nest_d;
            id_q <= id_d;
            err_q <= err_d;
        end
    end

    // Outputs decoded from state; the id tracks the live winner while requesting.
    always_comb begin
        int_req = (state_q == REQ);
        int_set = (state_q == SET);
        int_id = (state_q == REQ && any_elig) ? win : id_q;
        int_vec = VEC_BASE + ADDR_WIDTH_MEM'(int_id) * VEC_STRIDE;
        nest_cnt = nest_q;
        in_service = in_service_q;
        pending = pending_q;
        err = err_q;
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: scoreboard of expected pushes plus
// directed checks, with a second instance at nesting depth 2.
module tb_int_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  irq = '0;
    logic [3:0]  irq_mask = 4'b1111;
    logic        int_ack = 1'b0;
    logic        ret_valid = 1'b0;

    logic        int_req, int_set, err;
    logic [1:0]  int_id;
    logic [15:0] int_vec;
    logic [3:0]  nest_cnt, in_service, pending;

    logic        req2, set2, err2;
    logic [1:0]  id2;
    logic [15:0] vec2;
    logic [1:0]  nest2;
    logic [3:0]  insvc2, pend2;

    int checks = 0;
    int errors = 0;
    int sets2 = 0;
    int base2;
    logic prev_set = 1'b0;
    int exp_q[$];

    int_arbiter dut (
        .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask),
        .int_ack(int_ack), .ret_valid(ret_valid),
        .int_req(int_req), .int_set(int_set), .int_id(int_id),
        .int_vec(int_vec), .nest_cnt(nest_cnt), .in_service(in_service),
        .pending(pending), .err(err)
    );

    int_arbiter #(.STACK_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask),
        .int_ack(int_ack), .ret_valid(ret_valid),
        .int_req(req2), .int_set(set2), .int_id(id2),
        .int_vec(vec2), .nest_cnt(nest2), .in_service(insvc2),
        .pending(pend2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input int id);
        exp_q.push_back(id);
    endtask

    task automatic ret_pulse();
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
    endtask

    // Scoreboard: every observed push must match the next expected one.
    always @(negedge clk) begin
        if (int_set) begin
            if (prev_set) chk("set_width", 1, 0);
            if (exp_q.size() == 0) begin
                chk("set_unexpected", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("set_id", int_id, e);
                chk("set_vec", int_vec, 32'h100 + e * 32'h10);
            end
        end
        prev_set = int_set;
        if (set2) sets2++;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 want 1");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_req", int_req, 0);
        chk("rst_set", int_set, 0);
        chk("rst_id", int_id, 0);
        chk("rst_vec", int_vec, 16'h0100);
        chk("rst_nest", nest_cnt, 0);
        chk("rst_insvc", in_service, 0);
        chk("rst_pend", pending, 0);
        chk("rst_err", err, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single request on line 2.
        irq = 4'b0100;
        step();
        chk("t1_pend", pending, 4'b0100);
        chk("t1_noreq", int_req, 0);
        irq = 4'b0000;
        step();
        chk("t1_req", int_req, 1);
        chk("t1_id", int_id, 2);
        chk("t1_vec", int_vec, 16'h0120);
        step();
        step();
        int_ack = 1'b1;
        expect_push(2);
        step();
        int_ack = 1'b0;
        chk("t1_set", int_set, 1);
        chk("t1_nest_pre", nest_cnt, 0);
        step();
        chk("t1_set_off", int_set, 0);
        chk("t1_nest", nest_cnt, 1);
        chk("t1_insvc", in_service, 4'b0100);
        chk("t1_pend_clr", pending, 0);
        ret_pulse();
        chk("t1_ret", nest_cnt, 0);

        // Priority and preemption.
        irq = 4'b1010;
        step();
        irq = 4'b0000;
        step();
        chk("t2_req", int_req, 1);
        chk("t2_id", int_id, 1);
        int_ack = 1'b1;
        expect_push(1);
        step();
        int_ack = 1'b0;
        step();
        chk("t2_insvc1", in_service, 4'b0010);
        step();
        step();
        chk("t2_blocked", int_req, 0);
        chk("t2_pend3", pending, 4'b1000);
        irq = 4'b0001;
        step();
        irq = 4'b0000;
        step();
        chk("t2_req0", int_req, 1);
        chk("t2_id0", int_id, 0);
        int_ack = 1'b1;
        expect_push(0);
        step();
        int_ack = 1'b0;
        step();
        chk("t2_nest2", nest_cnt, 2);
        chk("t2_insvc2", in_service, 4'b0011);
        step();
        ret_pulse();
        chk("t2_ret1_nest", nest_cnt, 1);
        chk("t2_ret1_insvc", in_service, 4'b0010);
        ret_pulse();
        chk("t2_ret2_nest", nest_cnt, 0);
        step();
        chk("t2_req3", int_req, 1);
        chk("t2_id3", int_id, 3);
        int_ack = 1'b1;
        expect_push(3);
        step();
        int_ack = 1'b0;
        step();
        step();
        ret_pulse();
        chk("t2_clean", nest_cnt, 0);

        // Mask withdrawal.
        irq = 4'b0100;
        step();
        irq = 4'b0000;
        step();
        chk("t3_req", int_req, 1);
        irq_mask = 4'b1011;
        step();
        chk("t3_withdrawn", int_req, 0);
        step();
        chk("t3_noreq", int_req, 0);
        chk("t3_noset", int_set, 0);
        irq_mask = 4'b1111;
        step();
        chk("t3_back", int_req, 1);
        chk("t3_id", int_id, 2);
        int_ack = 1'b1;
        expect_push(2);
        step();
        int_ack = 1'b0;
        step();
        step();
        ret_pulse();

        // Protocol errors.
        chk("t4_err_pre", err, 0);
        ret_pulse();
        chk("t4_err", err, 1);
        chk("t4_nest", nest_cnt, 0);
        irq = 4'b0010;
        step();
        irq = 4'b0000;
        step();
        chk("t4_req", int_req, 1);
        ret_valid = 1'b1;
        int_ack = 1'b1;
        step();
        ret_valid = 1'b0;
        int_ack = 1'b0;
        chk("t4_noset", int_set, 0);
        chk("t4_reqheld", int_req, 1);
        int_ack = 1'b1;
        expect_push(1);
        step();
        int_ack = 1'b0;
        step();
        step();
        ret_pulse();
        chk("t4_clean", nest_cnt, 0);
        chk("t4_err_sticky", err, 1);

        // Depth limit on the depth-2 instance.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        base2 = sets2;
        irq = 4'b1000;
        step();
        irq = 4'b0000;
        step();
        chk("t5_req3", req2, 1);
        int_ack = 1'b1;
        expect_push(3);
        step();
        int_ack = 1'b0;
        step();
        step();
        irq = 4'b0100;
        step();
        irq = 4'b0000;
        step();
        chk("t5_req2", req2, 1);
        chk("t5_id2", id2, 2);
        int_ack = 1'b1;
        expect_push(2);
        step();
        int_ack = 1'b0;
        step();
        step();
        chk("t5_full", nest2, 2);
        irq = 4'b0010;
        step();
        irq = 4'b0000;
        step();
        chk("t5_d1_req", int_req, 1);
        chk("t5_d2_noreq", req2, 0);
        chk("t5_d2_pend", pend2, 4'b0010);
        step();
        chk("t5_d2_noreq2", req2, 0);
        ret_pulse();
        chk("t5_d2_nest", nest2, 1);
        step();
        chk("t5_d2_req", req2, 1);
        chk("t5_d2_id", id2, 1);
        int_ack = 1'b1;
        expect_push(1);
        step();
        int_ack = 1'b0;
        chk("t5_d2_set", set2, 1);
        step();
        chk("t5_d2_nest2", nest2, 2);
        chk("t5_d2_insvc", insvc2, 4'b1010);
        chk("t5_d2_sets", sets2 - base2, 3);
        step();

        // Reset during SET.
        irq = 4'b0001;
        step();
        irq = 4'b0000;
        step();
        chk("t6_req", int_req, 1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        chk("t6_set", int_set, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_set_off", int_set, 0);
        chk("t6_req_off", int_req, 0);
        chk("t6_nest", nest_cnt, 0);
        chk("t6_insvc", in_service, 0);
        chk("t6_pend", pending, 0);
        chk("t6_vec", int_vec, 16'h0100);
        chk("t6_err", err, 0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("t6_nest_after", nest_cnt, 0);
        chk("t6_noset", int_set, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
